// File: rtl/rf215_spi_arbiter.sv
// Two-master arbiter for the AT86RF215 SPI port: an unstallable HPS master with absolute priority
// and a fabric master using req/gnt, with a guaranteed CS-high guard time between owners.
module rf215_spi_arbiter #(
  parameter int unsigned GUARD_CYC   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hps_cs_n,
  input  logic       hps_sclk,
  input  logic       hps_mosi,
  output logic       hps_miso,
  input  logic       fab_req,
  output logic       fab_gnt,
  input  logic       fab_cs_n,
  input  logic       fab_sclk,
  input  logic       fab_mosi,
  output logic       fab_miso,
  output logic       rf_cs_n,
  output logic       rf_sclk,
  output logic       rf_mosi,
  input  logic       rf_miso,
  output logic [1:0] owner,
  output logic       hps_collision,
  input  logic       clr_collision
);

  localparam int unsigned CntW = $clog2(GUARD_CYC + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StHps   = 2'b01,
    StFab   = 2'b10,
    StGuard = 2'b11
  } state_e;

  logic [SYNC_STAGES-1:0] hps_sync_q, hps_sync_d;
  logic [SYNC_STAGES-1:0] sync_vld_q, sync_vld_d;
  logic                   hps_prev_q, hps_prev_d;
  logic                   hps_cs_s, hps_fall;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        guard_cnt_q, guard_cnt_d;
  logic                   cs_q, cs_d;
  logic                   gnt_q, gnt_d;
  logic                   coll_q, coll_d;
  logic                   coll_set;

  // The synchronizer resets high, so its output is not trusted until it has filled with real
  // samples; a CS already low out of reset therefore never looks like a falling edge.
  always_comb begin
    hps_sync_d = {hps_sync_q[SYNC_STAGES-2:0], hps_cs_n};
    sync_vld_d = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    hps_cs_s   = hps_sync_q[SYNC_STAGES-1];
    hps_prev_d = sync_vld_q[SYNC_STAGES-1] ? hps_cs_s : 1'b0;
    hps_fall   = hps_prev_q & ~hps_cs_s;
  end

  always_comb begin
    state_d     = state_q;
    guard_cnt_d = guard_cnt_q;
    coll_set    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hps_fall) begin
          state_d = StHps;
        end else if (fab_req) begin
          state_d = StFab;
        end
      end
      StHps: begin
        if (hps_cs_s) begin
          state_d     = StGuard;
          guard_cnt_d = CntW'(GUARD_CYC - 1);
        end
      end
      StFab: begin
        coll_set = hps_fall;
        if (!fab_req && fab_cs_n) begin
          state_d     = StGuard;
          guard_cnt_d = CntW'(GUARD_CYC - 1);
        end
      end
      StGuard: begin
        coll_set = hps_fall;
        if (guard_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          guard_cnt_d = guard_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    cs_d   = (state_d != StHps);
    gnt_d  = (state_d == StFab);
    coll_d = coll_set | (coll_q & ~clr_collision);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hps_sync_q  <= '1;
      sync_vld_q  <= '0;
      hps_prev_q  <= 1'b0;
      state_q     <= StIdle;
      guard_cnt_q <= '0;
      cs_q        <= 1'b1;
      gnt_q       <= 1'b0;
      coll_q      <= 1'b0;
    end else begin
      hps_sync_q  <= hps_sync_d;
      sync_vld_q  <= sync_vld_d;
      hps_prev_q  <= hps_prev_d;
      state_q     <= state_d;
      guard_cnt_q <= guard_cnt_d;
      cs_q        <= cs_d;
      gnt_q       <= gnt_d;
      coll_q      <= coll_d;
    end
  end

  // Fabric CS is passed through combinationally so the fabric master keeps full frame control.
  always_comb begin
    owner         = state_q;
    fab_gnt       = gnt_q;
    hps_collision = coll_q;
    rf_cs_n       = (state_q == StFab) ? fab_cs_n : cs_q;
    rf_sclk       = 1'b0;
    rf_mosi       = 1'b0;
    hps_miso      = 1'b0;
    fab_miso      = 1'b0;
    if (state_q == StHps) begin
      rf_sclk  = hps_sclk;
      rf_mosi  = hps_mosi;
      hps_miso = rf_miso;
    end else if (state_q == StFab) begin
      rf_sclk  = fab_sclk;
      rf_mosi  = fab_mosi;
      fab_miso = rf_miso;
    end
  end

endmodule

// File: tb/tb_rf215_spi_arbiter.sv
// Directed bench for rf215_spi_arbiter: datapath vector table per owner plus hand-written
// sequences for arbitration, guard timing, collisions and asynchronous reset.
module tb_rf215_spi_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       hps_cs_n = 1'b1, hps_sclk = 1'b0, hps_mosi = 1'b0, hps_miso;
  logic       fab_req = 1'b0, fab_gnt, fab_cs_n = 1'b1, fab_sclk = 1'b0, fab_mosi = 1'b0;
  logic       fab_miso;
  logic       rf_cs_n, rf_sclk, rf_mosi, rf_miso = 1'b0;
  logic [1:0] owner;
  logic       hps_collision, clr_collision = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  rf215_spi_arbiter #(
    .GUARD_CYC  (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hps_cs_n     (hps_cs_n),
    .hps_sclk     (hps_sclk),
    .hps_mosi     (hps_mosi),
    .hps_miso     (hps_miso),
    .fab_req      (fab_req),
    .fab_gnt      (fab_gnt),
    .fab_cs_n     (fab_cs_n),
    .fab_sclk     (fab_sclk),
    .fab_mosi     (fab_mosi),
    .fab_miso     (fab_miso),
    .rf_cs_n      (rf_cs_n),
    .rf_sclk      (rf_sclk),
    .rf_mosi      (rf_mosi),
    .rf_miso      (rf_miso),
    .owner        (owner),
    .hps_collision(hps_collision),
    .clr_collision(clr_collision)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] own;
    logic       hs, hm, fs, fm, rm;
    logic [3:0] exp;  // {rf_sclk, rf_mosi, hps_miso, fab_miso}
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_vectors(input logic [1:0] st);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].own == st) begin
        hps_sclk = vecs[i].hs;
        hps_mosi = vecs[i].hm;
        fab_sclk = vecs[i].fs;
        fab_mosi = vecs[i].fm;
        rf_miso  = vecs[i].rm;
        #1;
        check($sformatf("vec%0d_owner", i), owner, st);
        check($sformatf("vec%0d_data", i), {rf_sclk, rf_mosi, hps_miso, fab_miso}, vecs[i].exp);
      end
    end
    hps_sclk = 1'b0; hps_mosi = 1'b0; fab_sclk = 1'b0; fab_mosi = 1'b0; rf_miso = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010};
    vecs[1] = '{2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100};
    vecs[2] = '{2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1110};
    vecs[3] = '{2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0101};
    vecs[4] = '{2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1001};
    vecs[5] = '{2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1100};
    vecs[6] = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000};
    vecs[7] = '{2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[8] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000};
    vecs[9] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000};

    // Reset values, with rf_miso high to prove both MISO returns are gated.
    rf_miso = 1'b1;
    tick(3);
    check("reset_outputs",
          {owner, fab_gnt, hps_collision, rf_cs_n, rf_sclk, rf_mosi, fab_miso, hps_miso},
          {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    rf_miso = 1'b0;
    reset_n = 1'b1;
    tick(3);
    run_vectors(2'b00);

    // HPS-only access.
    hps_cs_n = 1'b0;
    tick(2);
    check("hps_cs_not_yet", {owner, rf_cs_n}, {2'b00, 1'b1});
    tick(1);
    check("hps_cs_latency", {owner, rf_cs_n}, {2'b01, 1'b0});
    run_vectors(2'b01);
    hps_cs_n = 1'b1;
    tick(2);
    check("hps_still_owner", {owner, rf_cs_n}, {2'b01, 1'b0});
    tick(1);
    check("hps_guard_entry", {owner, rf_cs_n}, {2'b11, 1'b1});
    run_vectors(2'b11);
    tick(3);
    check("hps_guard_last", {owner, rf_cs_n}, {2'b11, 1'b1});
    tick(1);
    check("hps_guard_done", {owner, rf_cs_n, hps_collision}, {2'b00, 1'b1, 1'b0});

    // Fabric-only access.
    fab_req = 1'b1;
    tick(1);
    check("fab_grant", {owner, fab_gnt, rf_cs_n}, {2'b10, 1'b1, 1'b1});
    fab_cs_n = 1'b0;
    #1;
    check("fab_cs_pass", rf_cs_n, 1'b0);
    run_vectors(2'b10);
    fab_cs_n = 1'b1;
    fab_req  = 1'b0;
    #1;
    check("fab_cs_release", rf_cs_n, 1'b1);
    tick(1);
    check("fab_release_edge", {owner, fab_gnt, rf_cs_n}, {2'b11, 1'b0, 1'b1});
    tick(3);
    check("fab_guard_last", owner, 2'b11);
    tick(1);
    check("fab_guard_done", owner, 2'b00);

    // Same-cycle HPS fall and fabric request: HPS wins, fabric stays pending.
    hps_cs_n = 1'b0;
    tick(2);
    fab_req = 1'b1;
    tick(1);
    check("tie_hps_wins", {owner, fab_gnt}, {2'b01, 1'b0});
    tick(2);
    check("tie_fab_ignored", {owner, fab_gnt}, {2'b01, 1'b0});
    hps_cs_n = 1'b1;
    tick(3);
    check("tie_guard", {owner, fab_gnt}, {2'b11, 1'b0});
    tick(4);
    check("tie_idle", {owner, fab_gnt}, {2'b00, 1'b0});
    tick(1);
    check("tie_fab_granted", {owner, fab_gnt}, {2'b10, 1'b1});

    // HPS falls while the fabric owns the bus.
    fab_cs_n = 1'b0;
    hps_cs_n = 1'b0;
    hps_sclk = 1'b1;
    hps_mosi = 1'b1;
    rf_miso  = 1'b1;
    tick(3);
    check("coll_set", {hps_collision, owner, rf_cs_n}, {1'b1, 2'b10, 1'b0});
    check("coll_fab_pins", {rf_sclk, rf_mosi, hps_miso, fab_miso}, 4'b0001);
    hps_sclk = 1'b0; hps_mosi = 1'b0; rf_miso = 1'b0;
    clr_collision = 1'b1;
    tick(1);
    clr_collision = 1'b0;
    check("coll_clear", hps_collision, 1'b0);
    // Clear and a new collision in the same cycle: set wins.
    hps_cs_n = 1'b1;
    tick(3);
    hps_cs_n = 1'b0;
    tick(2);
    clr_collision = 1'b1;
    tick(1);
    clr_collision = 1'b0;
    check("coll_set_wins", hps_collision, 1'b1);
    clr_collision = 1'b1;
    tick(1);
    clr_collision = 1'b0;
    check("coll_clear2", hps_collision, 1'b0);

    // Request drops mid-frame: grant held until fab_cs_n rises.
    fab_req = 1'b0;
    tick(2);
    check("fab_hold", {owner, fab_gnt, rf_cs_n}, {2'b10, 1'b1, 1'b0});
    fab_cs_n = 1'b1;
    tick(1);
    check("fab_hold_release", {owner, fab_gnt, rf_cs_n}, {2'b11, 1'b0, 1'b1});
    tick(6);
    check("low_cs_in_idle", {owner, hps_collision}, {2'b00, 1'b0});
    hps_cs_n = 1'b1;
    tick(4);

    // Asynchronous reset during an HPS access.
    hps_cs_n = 1'b0;
    tick(3);
    check("rst_pre_hps", {owner, rf_cs_n}, {2'b01, 1'b0});
    reset_n = 1'b0;
    #1;
    check("rst_async", {owner, rf_cs_n, fab_gnt}, {2'b00, 1'b1, 1'b0});
    #2;
    reset_n = 1'b1;
    tick(6);
    check("rst_low_cs_ignored", {owner, rf_cs_n, hps_collision}, {2'b00, 1'b1, 1'b0});
    hps_cs_n = 1'b1;
    tick(4);
    hps_cs_n = 1'b0;
    tick(3);
    check("rst_rearmed", {owner, rf_cs_n}, {2'b01, 1'b0});
    hps_cs_n = 1'b1;
    tick(8);
    check("final_idle", owner, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf215_spi_arbiter.md
Name: rf215_spi_arbiter

Overview:
- Shares the single AT86RF215 SPI port between two masters:
  - the HPS SPI master, whose CS has already been fused to one low pulse per 3-byte access;
  - a fabric-side SPI master, e.g. an FPGA register sequencer.
- The HPS cannot be stalled, so it has absolute priority. The fabric uses a req/gnt handshake.
- A guaranteed CS-high guard time is inserted between owners.
- Sits between the CS fuser output / fabric master and the RF215 pins.

Parameters:
- GUARD_CYC, 4: clk cycles rf_cs_n is held high after any ownership release; must be ≥1.
- SYNC_STAGES, 2: synchronizer depth for hps_cs_n into clk; must be ≥2.

Ports:
- clk  in  1  system clock, ≥8× SCLK.
- reset_n  in  1  asynchronous, active-low reset.
- hps_cs_n  in  1  fused HPS chip select (async to clk).
- hps_sclk  in  1  HPS SPI clock.
- hps_mosi  in  1  HPS MOSI.
- hps_miso  out  1  MISO returned to HPS.
- fab_req  in  1  fabric bus request (level).
- fab_gnt  out  1  fabric bus grant.
- fab_cs_n  in  1  fabric chip select (clk domain).
- fab_sclk  in  1  fabric SPI clock.
- fab_mosi  in  1  fabric MOSI.
- fab_miso  out  1  MISO returned to fabric.
- rf_cs_n  out  1  chip select to RF215.
- rf_sclk  out  1  SPI clock to RF215.
- rf_mosi  out  1  MOSI to RF215.
- rf_miso  in  1  MISO from RF215.
- owner  out  2  00 = none, 01 = HPS, 10 = fabric, 11 = guard.
- hps_collision  out  1  sticky error: HPS access started while the bus was not available.
- clr_collision  in  1  synchronous clear of hps_collision.

Behaviour:
- Reset values: state IDLE, owner=00, fab_gnt=0, hps_collision=0, rf_cs_n=1, rf_sclk=0, rf_mosi=0, fab_miso=0, hps_miso=0. Synchronizer flops reset to 1.
- HPS CS handling:
  - hps_cs_s is hps_cs_n after SYNC_STAGES flops.
  - hps_fall = previous hps_cs_s high AND current hps_cs_s low.
- FSM states (owner encoding) and transitions:
  - IDLE (00):
    - hps_fall → HPS.
    - else fab_req → FAB with fab_gnt=1 from the next cycle.
    - Simultaneous hps_fall and fab_req: HPS wins; fab_req stays pending.
  - HPS (01):
    - rf_cs_n = 0, registered, asserted on the transition cycle.
    - Exit when hps_cs_s returns high → GUARD.
    - fab_req is ignored while in this state.
  - FAB (10):
    - rf_cs_n = fab_cs_n, combinational.
    - Exit when fab_req=0 AND fab_cs_n=1 → GUARD; fab_gnt drops on that same edge.
    - If fab_req drops while fab_cs_n=0, remain in FAB with gnt held until fab_cs_n rises.
  - GUARD (11):
    - rf_cs_n = 1; counter loads GUARD_CYC-1 on entry and decrements to 0, then → IDLE.
    - Total time high is exactly GUARD_CYC cycles. Counter width is clog2(GUARD_CYC+1).
- Collision:
  - hps_fall in FAB or GUARD sets hps_collision. That HPS access is dropped, never forwarded.
  - HPS is granted only on a falling edge seen in IDLE. A CS already low on entering IDLE is not granted.
  - clr_collision clears the flag. If clr_collision and a new collision occur in the same cycle, set wins.
- Datapath, combinational mux on the registered owner:
  - rf_sclk/rf_mosi come from the owner's inputs when owner is 01 or 10; otherwise 0 (CPOL=0 idle).
  - rf_miso goes to the owner's *_miso; the non-owner's MISO is 0.
- Latency:
  - HPS fall to rf_cs_n low: SYNC_STAGES+1 clk (3 at default). The HPS CS-to-first-SCLK lead must be ≥4 clk.
  - fab_req to fab_gnt: 1 clk from IDLE. Fabric holds fab_cs_n=1 until fab_gnt is seen.
- Reset mid-transaction: all outputs return to reset values immediately (async). The FSM then needs a fresh HPS falling edge or fab_req.

Test Plan:
- HPS only, GUARD_CYC=4: hps_cs_n low for 3 bytes → rf_cs_n low 3 clk later; rf_sclk/mosi mirror HPS; hps_miso = rf_miso; after rise, owner=11 for 4 clk, then 00; no collision.
- Fabric only: fab_req=1 → fab_gnt=1 next clk, owner=10; 24-bit frame passes through; fab_req=0 with fab_cs_n=1 → gnt=0 the same edge, rf_cs_n high 4 clk.
- Same-cycle hps_fall and fab_req in IDLE: owner=01, fab_gnt stays 0. After HPS and guard, fab_gnt=1 with no extra request edge.
- HPS CS falls while owner=10: hps_collision=1; rf pins follow the fabric only. clr_collision=1 for 1 clk → flag 0.
- fab_req drops while fab_cs_n=0: owner stays 10 and gnt stays 1 until fab_cs_n rises, then GUARD.
- reset_n pulsed low during an HPS access: rf_cs_n=1 and owner=00 asynchronously. The still-low HPS CS after reset is not granted and does not set a collision.
